// File: rtl/fll_cfg_responder.sv
// FLL configuration responder: four-phase req/ack register port, CFG1 multiplier/divider
// outputs, and a lock indication that drops on each CFG1 write and returns after a settle count.
module fll_cfg_responder #(
  parameter int unsigned LOCK_RST_CYCLES = 16,
  parameter logic [15:0] MULT_RST        = 16'h05F5,
  parameter logic [3:0]  DIV_RST         = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fll_req_i,
  input  logic        fll_wrn_i,
  input  logic [1:0]  fll_add_i,
  input  logic [31:0] fll_data_i,
  output logic        fll_ack_o,
  output logic [31:0] fll_r_data_o,
  output logic        fll_lock_o,
  output logic [15:0] cfg_mult_o,
  output logic [3:0]  cfg_div_o
);

  localparam logic [15:0] LOCK_RST = 16'(LOCK_RST_CYCLES);

  typedef enum logic {
    IDLE,
    ACK
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic [19:0] cfg1_q, cfg1_d;
  logic [15:0] cfg2_q, cfg2_d;
  logic [31:0] scratch_q, scratch_d;
  logic [15:0] cnt_q, cnt_d;
  logic        lock;
  logic [31:0] rd_val;

  assign lock         = (cnt_q == '0);
  assign fll_lock_o   = lock;
  assign fll_ack_o    = (state_q == ACK);
  assign fll_r_data_o = rdata_q;
  assign cfg_mult_o   = cfg1_q[15:0];
  assign cfg_div_o    = cfg1_q[19:16];

  always_comb begin
    rd_val = '0;
    case (fll_add_i)
      2'd0:    rd_val = {lock, 11'b0, cfg1_q};
      2'd1:    rd_val = {12'b0, cfg1_q};
      2'd2:    rd_val = {16'b0, cfg2_q};
      default: rd_val = scratch_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    rdata_d   = rdata_q;
    cfg1_d    = cfg1_q;
    cfg2_d    = cfg2_q;
    scratch_d = scratch_q;
    cnt_d     = lock ? cnt_q : cnt_q - 16'd1;
    case (state_q)
      IDLE: begin
        if (fll_req_i) begin
          state_d = ACK;
          if (fll_wrn_i) begin
            rdata_d = rd_val;
          end else begin
            case (fll_add_i)
              2'd1: begin
                cfg1_d = fll_data_i[19:0];
                // A zero settle count still yields one unlocked cycle.
                cnt_d  = (cfg2_q == '0) ? 16'd1 : cfg2_q;
              end
              2'd2:    cfg2_d    = fll_data_i[15:0];
              2'd3:    scratch_d = fll_data_i;
              default: ;
            endcase
          end
        end
      end
      ACK: begin
        if (!fll_req_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rdata_q   <= '0;
      cfg1_q    <= {DIV_RST, MULT_RST};
      cfg2_q    <= LOCK_RST;
      scratch_q <= '0;
      cnt_q     <= LOCK_RST;
    end else begin
      state_q   <= state_d;
      rdata_q   <= rdata_d;
      cfg1_q    <= cfg1_d;
      cfg2_q    <= cfg2_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fll_cfg_responder.sv
// Self-checking bench for fll_cfg_responder: constant vector table, hand-written corner
// sequences, and randomized traffic against a transaction-level reference model.
module tb_fll_cfg_responder;

  localparam int unsigned LOCKN = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        wrn = 1'b0;
  logic [1:0]  add = '0;
  logic [31:0] wdata = '0;
  logic        ack;
  logic [31:0] rdata;
  logic        lock;
  logic [15:0] mult;
  logic [3:0]  div;

  fll_cfg_responder #(
    .LOCK_RST_CYCLES(LOCKN),
    .MULT_RST(16'h05F5),
    .DIV_RST(4'd1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .fll_req_i(req),
    .fll_wrn_i(wrn),
    .fll_add_i(add),
    .fll_data_i(wdata),
    .fll_ack_o(ack),
    .fll_r_data_o(rdata),
    .fll_lock_o(lock),
    .cfg_mult_o(mult),
    .cfg_div_o(div)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: register contents plus the edge number at which lock returns.
  int          now = 0;
  int          lock_at = 0;
  bit          m_ack = 0;
  logic [31:0] m_rdata = '0;
  logic [19:0] m_cfg1 = '0;
  logic [15:0] m_cfg2 = '0;
  logic [31:0] m_scr = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got %h expected %h", nm, now, act, exp);
    end
  endtask

  function automatic int unsigned settle(input logic [15:0] c);
    return (c == 0) ? 1 : int'(c);
  endfunction

  // Apply current inputs for one edge, advance the model, compare all outputs.
  task automatic tick();
    bit m_lock;
    m_lock = (now >= lock_at);
    if (rst) begin
      m_ack = 0; m_rdata = '0; m_cfg1 = {4'd1, 16'h05F5}; m_cfg2 = 16'(LOCKN);
      m_scr = '0; lock_at = now + 1 + int'(LOCKN);
    end else if (!m_ack && req) begin
      m_ack = 1;
      if (wrn) begin
        case (add)
          2'd0: m_rdata = {m_lock, 11'b0, m_cfg1};
          2'd1: m_rdata = {12'b0, m_cfg1};
          2'd2: m_rdata = {16'b0, m_cfg2};
          default: m_rdata = m_scr;
        endcase
      end else begin
        case (add)
          2'd1: begin m_cfg1 = wdata[19:0]; lock_at = now + 1 + int'(settle(m_cfg2)); end
          2'd2: m_cfg2 = wdata[15:0];
          2'd3: m_scr = wdata;
          default: ;
        endcase
      end
    end else if (m_ack && !req) begin
      m_ack = 0;
    end
    @(posedge clk);
    now++;
    #1;
    chk("ack", 32'(ack), 32'(m_ack));
    chk("rdata", rdata, m_rdata);
    chk("lock", 32'(lock), 32'(now >= lock_at));
    chk("mult", 32'(mult), 32'(m_cfg1[15:0]));
    chk("div", 32'(div), 32'(m_cfg1[19:16]));
  endtask

  task automatic xfer(input bit r, input logic [1:0] a, input logic [31:0] d);
    req = 1'b1; wrn = r; add = a; wdata = d;
    tick();
  endtask

  task automatic drop();
    req = 1'b0;
    tick();
  endtask

  typedef struct {
    bit          req;
    bit          wrn;
    logic [1:0]  add;
    logic [31:0] data;
    bit          e_ack;
    logic [31:0] e_rdata;
    bit          e_lock;
    logic [15:0] e_mult;
    logic [3:0]  e_div;
  } vec_t;

  vec_t vt[17];

  initial begin
    int k;
    //          req wrn add  data          ack rdata          lock mult     div
    vt[0]  = '{1, 1, 2'd0, 32'h0,         1, 32'h8001_05F5, 1, 16'h05F5, 4'd1};
    vt[1]  = '{0, 1, 2'd0, 32'h0,         0, 32'h8001_05F5, 1, 16'h05F5, 4'd1};
    vt[2]  = '{1, 0, 2'd2, 32'h3,         1, 32'h8001_05F5, 1, 16'h05F5, 4'd1};
    vt[3]  = '{0, 0, 2'd2, 32'h3,         0, 32'h8001_05F5, 1, 16'h05F5, 4'd1};
    vt[4]  = '{1, 0, 2'd1, 32'h0002_0100, 1, 32'h8001_05F5, 0, 16'h0100, 4'd2};
    vt[5]  = '{0, 0, 2'd1, 32'h0,         0, 32'h8001_05F5, 0, 16'h0100, 4'd2};
    vt[6]  = '{0, 0, 2'd1, 32'h0,         0, 32'h8001_05F5, 0, 16'h0100, 4'd2};
    vt[7]  = '{0, 0, 2'd1, 32'h0,         0, 32'h8001_05F5, 1, 16'h0100, 4'd2};
    vt[8]  = '{1, 1, 2'd1, 32'h0,         1, 32'h0002_0100, 1, 16'h0100, 4'd2};
    vt[9]  = '{0, 1, 2'd1, 32'h0,         0, 32'h0002_0100, 1, 16'h0100, 4'd2};
    vt[10] = '{1, 0, 2'd0, 32'hFFFF_FFFF, 1, 32'h0002_0100, 1, 16'h0100, 4'd2};
    vt[11] = '{1, 0, 2'd3, 32'h0000_1234, 1, 32'h0002_0100, 1, 16'h0100, 4'd2};
    vt[12] = '{0, 0, 2'd3, 32'h0,         0, 32'h0002_0100, 1, 16'h0100, 4'd2};
    vt[13] = '{1, 1, 2'd3, 32'h0,         1, 32'h0000_0000, 1, 16'h0100, 4'd2};
    vt[14] = '{0, 1, 2'd3, 32'h0,         0, 32'h0000_0000, 1, 16'h0100, 4'd2};
    vt[15] = '{1, 1, 2'd2, 32'h0,         1, 32'h0000_0003, 1, 16'h0100, 4'd2};
    vt[16] = '{0, 1, 2'd2, 32'h0,         0, 32'h0000_0003, 1, 16'h0100, 4'd2};

    // Reset, then idle: lock must appear exactly LOCKN edges after the reset edge.
    rst = 1'b1;
    tick();
    tick();
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_mult", 32'(mult), 32'h05F5);
    chk("rst_div", 32'(div), 32'd1);
    rst = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 15) chk("t1_lock15", 32'(lock), 32'd0);
      if (i == 16) chk("t1_lock16", 32'(lock), 32'd1);
    end

    for (int i = 0; i < 17; i++) begin
      req = vt[i].req; wrn = vt[i].wrn; add = vt[i].add; wdata = vt[i].data;
      tick();
      chk($sformatf("vec%0d_ack", i), 32'(ack), 32'(vt[i].e_ack));
      chk($sformatf("vec%0d_rdata", i), rdata, vt[i].e_rdata);
      chk($sformatf("vec%0d_lock", i), 32'(lock), 32'(vt[i].e_lock));
      chk($sformatf("vec%0d_mult", i), 32'(mult), 32'(vt[i].e_mult));
      chk($sformatf("vec%0d_div", i), 32'(div), 32'(vt[i].e_div));
    end

    // Back-to-back CFG1 writes: the second restarts the settle count.
    xfer(0, 2'd2, 32'd8);
    drop();
    xfer(0, 2'd1, 32'h0003_0040);
    drop();
    xfer(0, 2'd1, 32'h0004_0080);
    chk("t4_lock_at_wr", 32'(lock), 32'd0);
    k = 99;
    req = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (lock && k == 99) k = i;
    end
    chk("t4_settle", 32'(k), 32'd8);

    // Zero settle count gives a single unlocked cycle; STATUS writes are inert.
    xfer(0, 2'd2, 32'd0);
    drop();
    xfer(0, 2'd1, 32'h0001_05F5);
    chk("t5_lock_low", 32'(lock), 32'd0);
    drop();
    chk("t5_lock_high", 32'(lock), 32'd1);
    xfer(0, 2'd0, 32'hFFFF_FFFF);
    chk("t5_status_ack", 32'(ack), 32'd1);
    chk("t5_status_mult", 32'(mult), 32'h05F5);
    chk("t5_status_div", 32'(div), 32'd1);
    drop();

    // Reset in the middle of an acknowledged read aborts it and clears SCRATCH.
    xfer(0, 2'd3, 32'hDEAD_BEEF);
    drop();
    xfer(1, 2'd0, 32'h0);
    chk("t6_ack_before", 32'(ack), 32'd1);
    rst = 1'b1;
    tick();
    chk("t6_ack_rst", 32'(ack), 32'd0);
    rst = 1'b0;
    drop();
    xfer(1, 2'd3, 32'h0);
    chk("t6_scratch", rdata, 32'd0);
    drop();

    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      req = ($urandom_range(0, 2) != 0);
      wrn = $urandom_range(0, 1) == 1;
      add = 2'($urandom_range(0, 3));
      wdata = $urandom;
      if (add == 2'd2 && $urandom_range(0, 3) != 0) wdata[15:0] = 16'($urandom_range(0, 12));
      tick();
    end
    rst = 1'b0;
    req = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
